am_insert_fsm: RTL and testbench
================================

Name: am_insert_fsm

Overview:
- TX-side counterpart of the RX deskew/alignment logic in the 100GbE PCS.
- Periodically inserts one alignment-marker (AM) block per PCS lane into the 66b block stream, ahead of lane distribution.
- Back-pressures upstream during insertion so no data block is lost. Rate compensation happens upstream by idle deletion.
- AM block contents come from an external per-lane table, addressed by this block.

Parameters:
- N_LANES, 20, number of PCS lanes; equals the number of AM blocks per insertion burst.
- AM_PERIOD, 16384, blocks per lane between AMs, AM included. Total period is N_LANES*AM_PERIOD enabled cycles.
- NB_BLOCK, 66, block width.
- NB_COUNT, $clog2(N_LANES*AM_PERIOD), width of the period counter.
- NB_LANE, $clog2(N_LANES), width of the lane index.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  block strobe; all state advances only on cycles with i_enable=1.
- i_force_am  in  1  restart the AM period; a burst starts on the next enabled cycle.
- i_data  in  NB_BLOCK  upstream data block; held by upstream while o_stall=1.
- i_am_block  in  NB_BLOCK  AM block from the table for lane o_am_lane_index, valid in the same cycle.
- o_data  out  NB_BLOCK  registered output block (data or AM).
- o_valid  out  1  registered; o_data is valid.
- o_am_flag  out  1  registered; o_data is an AM block.
- o_period_start  out  1  registered 1-cycle pulse with the lane-0 AM.
- o_stall  out  1  combinational; upstream block not consumed this cycle.
- o_am_lane_index  out  NB_LANE  combinational table address.

Behaviour:
- States, one-hot: INIT=3'b001, INSERT=3'b010, DATA=3'b100.
- Reset values: state=INIT, lane_cnt=0, blk_cnt=0.
- Reset values: o_data=0, o_valid=0, o_am_flag=0, o_period_start=0.
- In INIT, o_stall=1.
- i_reset has priority over everything. Reset mid-burst aborts the burst; the next burst restarts at lane 0.
- On cycles with i_enable=0: state and counters hold, o_valid<=0, o_am_flag<=0, o_period_start<=0, o_data holds.
- INIT: o_stall=1. On an enabled cycle go to INSERT with lane_cnt=0. No output this cycle (o_valid<=0).
- INSERT:
  - o_stall=1, o_am_lane_index=lane_cnt.
  - Each enabled cycle: o_data<=i_am_block, o_valid<=1, o_am_flag<=1, o_period_start<=(lane_cnt==0).
  - lane_cnt increments each enabled cycle.
  - On lane_cnt==N_LANES-1: go to DATA, lane_cnt<=0, blk_cnt<=0.
- DATA:
  - o_stall=0, o_am_lane_index=0.
  - Each enabled cycle: o_data<=i_data, o_valid<=1, o_am_flag<=0, blk_cnt increments.
  - On blk_cnt==N_LANES*(AM_PERIOD-1)-1: go to INSERT (last data block of the period).
- Period: exactly N_LANES AM blocks followed by N_LANES*(AM_PERIOD-1) data blocks, repeating with no gaps between enabled cycles.
- Latency: 1 enabled cycle, input to o_data.
- i_force_am:
  - In DATA: the current cycle's data block is still output; next state is INSERT; blk_cnt<=0.
  - In INSERT: ignored; the burst completes normally.
  - In INIT: no effect.
- i_force_am coinciding with the natural end-of-period in DATA gives the same result: a single burst.
- Counter widths: blk_cnt compares against constants only and never exceeds N_LANES*(AM_PERIOD-1)-1. lane_cnt never exceeds N_LANES-1.
- o_stall and o_am_lane_index depend only on state and lane_cnt, not on i_enable.

Test Plan (N_LANES=4, AM_PERIOD=4, i_enable=1 unless stated):
- Reset release, then stream data D0,D1,...:
  - First 4 valid outputs are AM lanes 0..3 with o_am_flag=1 and o_period_start=1 only on lane 0.
  - Then 12 data blocks D0..D11 with o_am_flag=0, then AM lanes 0..3 again.
  - o_stall=1 exactly on the INIT cycle and the 4 INSERT cycles.
- i_enable toggled 1,0,1,0 across a burst: lanes still 0,1,2,3 in order; o_valid=0 on disabled cycles; no data block dropped or duplicated.
- i_force_am pulsed on the 5th data cycle (D4): D4 is output, next 4 outputs are AMs, then D5 follows; the next burst occurs after 12 more data blocks.
- i_force_am held high through the entire INSERT: exactly one burst of 4 AMs.
- i_reset asserted during lane 2 of a burst: next cycle all outputs are 0; after release, one INIT cycle, then a burst starting at lane 0.
- Upstream check: scoreboard over 3 periods confirms the data order is preserved and every data block appears exactly once.

Source files
------------

// File: rtl/am_insert_if.sv
// Block-stream interface between upstream PCS logic and the AM inserter.
// The master drives blocks and strobes; the slave returns the merged stream, stall and table address.
interface am_insert_if #(
    parameter int NB_BLOCK = 66,
    parameter int NB_LANE  = 5
);
    logic                i_enable;
    logic                i_force_am;
    logic [NB_BLOCK-1:0] i_data;
    logic [NB_BLOCK-1:0] i_am_block;
    logic [NB_BLOCK-1:0] o_data;
    logic                o_valid;
    logic                o_am_flag;
    logic                o_period_start;
    logic                o_stall;
    logic [NB_LANE-1:0]  o_am_lane_index;

    modport master (
        output i_enable, i_force_am, i_data, i_am_block,
        input  o_data, o_valid, o_am_flag, o_period_start, o_stall, o_am_lane_index
    );

    modport slave (
        input  i_enable, i_force_am, i_data, i_am_block,
        output o_data, o_valid, o_am_flag, o_period_start, o_stall, o_am_lane_index
    );
endinterface

// File: rtl/am_insert_fsm.sv
// Alignment-marker inserter: emits one AM block per PCS lane every AM period,
// stalling upstream during the burst so no data block is lost.
module am_insert_fsm #(
    parameter int N_LANES   = 20,
    parameter int AM_PERIOD = 16384,
    parameter int NB_BLOCK  = 66,
    parameter int NB_COUNT  = $clog2(N_LANES * AM_PERIOD),
    parameter int NB_LANE   = $clog2(N_LANES)
) (
    input logic         i_clock,
    input logic         i_reset,
    am_insert_if.slave  bus
);
    localparam logic [2:0] INIT   = 3'b001;
    localparam logic [2:0] INSERT = 3'b010;
    localparam logic [2:0] DATA   = 3'b100;

    localparam logic [NB_LANE-1:0]  LAST_LANE = NB_LANE'(N_LANES - 1);
    localparam logic [NB_COUNT-1:0] LAST_BLK  = NB_COUNT'(N_LANES * (AM_PERIOD - 1) - 1);

    logic [2:0]          state_reg, state_next;
    logic [NB_LANE-1:0]  lane_cnt_reg, lane_cnt_next;
    logic [NB_COUNT-1:0] blk_cnt_reg, blk_cnt_next;
    logic [NB_BLOCK-1:0] data_reg, data_next;
    logic                valid_reg, valid_next;
    logic                am_flag_reg, am_flag_next;
    logic                period_start_reg, period_start_next;
    logic                stall;
    logic [NB_LANE-1:0]  lane_index;

    // State register; FSM and counters only advance on enabled cycles.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg        <= INIT;
            lane_cnt_reg     <= '0;
            blk_cnt_reg      <= '0;
            data_reg         <= '0;
            valid_reg        <= 1'b0;
            am_flag_reg      <= 1'b0;
            period_start_reg <= 1'b0;
        end else begin
            if (bus.i_enable) begin
                state_reg    <= state_next;
                lane_cnt_reg <= lane_cnt_next;
                blk_cnt_reg  <= blk_cnt_next;
            end
            data_reg         <= data_next;
            valid_reg        <= valid_next;
            am_flag_reg      <= am_flag_next;
            period_start_reg <= period_start_next;
        end
    end

    // Next-state logic. A forced AM in DATA and the natural period end both
    // lead to a single burst; a force during INSERT is ignored.
    always_comb begin
        state_next    = state_reg;
        lane_cnt_next = lane_cnt_reg;
        blk_cnt_next  = blk_cnt_reg;
        case (state_reg)
            INIT: begin
                state_next    = INSERT;
                lane_cnt_next = '0;
            end
            INSERT: begin
                if (lane_cnt_reg == LAST_LANE) begin
                    state_next    = DATA;
                    lane_cnt_next = '0;
                    blk_cnt_next  = '0;
                end else begin
                    lane_cnt_next = lane_cnt_reg + NB_LANE'(1);
                end
            end
            DATA: begin
                if (bus.i_force_am || blk_cnt_reg == LAST_BLK) begin
                    state_next   = INSERT;
                    blk_cnt_next = '0;
                end else begin
                    blk_cnt_next = blk_cnt_reg + NB_COUNT'(1);
                end
            end
            default: begin
                state_next    = INIT;
                lane_cnt_next = '0;
                blk_cnt_next  = '0;
            end
        endcase
    end

    // Output logic: stall/table address from state only, registered outputs
    // loaded only on enabled cycles (o_data holds otherwise).
    always_comb begin
        stall             = 1'b1;
        lane_index        = '0;
        data_next         = data_reg;
        valid_next        = 1'b0;
        am_flag_next      = 1'b0;
        period_start_next = 1'b0;
        case (state_reg)
            INSERT: begin
                lane_index = lane_cnt_reg;
                if (bus.i_enable) begin
                    data_next         = bus.i_am_block;
                    valid_next        = 1'b1;
                    am_flag_next      = 1'b1;
                    period_start_next = (lane_cnt_reg == '0);
                end
            end
            DATA: begin
                stall = 1'b0;
                if (bus.i_enable) begin
                    data_next  = bus.i_data;
                    valid_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.o_data          = data_reg;
    assign bus.o_valid         = valid_reg;
    assign bus.o_am_flag       = am_flag_reg;
    assign bus.o_period_start  = period_start_reg;
    assign bus.o_stall         = stall;
    assign bus.o_am_lane_index = lane_index;

endmodule

// File: tb/tb_am_insert_fsm.sv
// Randomized bench for am_insert_fsm against a period-position reference model.
module tb_am_insert_fsm;
    localparam int N_LANES   = 4;
    localparam int AM_PERIOD = 4;
    localparam int NB_BLOCK  = 66;
    localparam int NB_LANE   = 2;
    localparam int PERIOD    = N_LANES * AM_PERIOD;
    localparam int DEPTH     = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    am_insert_if #(.NB_BLOCK(NB_BLOCK), .NB_LANE(NB_LANE)) bus ();

    am_insert_fsm #(
        .N_LANES(N_LANES), .AM_PERIOD(AM_PERIOD), .NB_BLOCK(NB_BLOCK), .NB_LANE(NB_LANE)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus(bus)
    );

    logic [NB_BLOCK-1:0] am_table [N_LANES];
    logic [NB_BLOCK-1:0] dmem [DEPTH];

    // Reference model: position inside the period (0..N_LANES-1 = AM lanes, rest = data).
    bit                  m_init;
    int                  m_pos;
    int                  m_rd;
    int                  up_idx;
    int                  cyc;
    int                  checks;
    int                  failures;
    logic                exp_valid, exp_flag, exp_ps;
    logic [NB_BLOCK-1:0] exp_data;
    logic                pre_stall, obs_stall;
    logic [NB_LANE-1:0]  pre_idx, obs_idx;

    task automatic tick(input bit en, input bit frc, input bit rs);
        bit consume;
        rst             = rs;
        bus.i_enable    = en;
        bus.i_force_am  = frc;
        bus.i_data      = dmem[up_idx % DEPTH];
        #1;
        bus.i_am_block  = am_table[bus.o_am_lane_index];
        obs_stall       = bus.o_stall;
        obs_idx         = bus.o_am_lane_index;
        pre_stall       = m_init || (m_pos < N_LANES);
        pre_idx         = (!m_init && m_pos < N_LANES) ? NB_LANE'(m_pos) : '0;
        consume         = en && !rs && !bus.o_stall;
        @(posedge clk);
        if (rs) begin
            m_init = 1'b1; m_pos = 0;
            exp_valid = 0; exp_flag = 0; exp_ps = 0; exp_data = '0;
        end else if (!en) begin
            exp_valid = 0; exp_flag = 0; exp_ps = 0;
        end else if (m_init) begin
            m_init = 1'b0; m_pos = 0;
            exp_valid = 0; exp_flag = 0; exp_ps = 0;
        end else if (m_pos < N_LANES) begin
            exp_data = am_table[m_pos];
            exp_valid = 1; exp_flag = 1; exp_ps = (m_pos == 0);
            m_pos++;
        end else begin
            exp_data = dmem[m_rd % DEPTH];
            m_rd++;
            exp_valid = 1; exp_flag = 0; exp_ps = 0;
            m_pos = (frc || m_pos == PERIOD - 1) ? 0 : m_pos + 1;
        end
        if (consume) up_idx++;
        cyc++;
        #1;
        if (bus.o_valid)
            $display("cyc=%0d valid am=%b ps=%b data=%h", cyc, bus.o_am_flag, bus.o_period_start, bus.o_data);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            checks++;
            if ({bus.o_valid, bus.o_am_flag, bus.o_period_start, bus.o_data} !== {3'b000, {NB_BLOCK{1'b0}}}) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got v/am/ps=%b%b%b data=%h exp all zero",
                         cyc, bus.o_valid, bus.o_am_flag, bus.o_period_start, bus.o_data);
            end
            if (i > 0) begin
                checks++;
                if ({obs_stall, obs_idx} !== {1'b1, {NB_LANE{1'b0}}}) begin
                    failures++;
                    $display("FAIL reset_stall cyc=%0d got stall=%b idx=%0d exp stall=1 idx=0", cyc, obs_stall, obs_idx);
                end
            end
        end
    endtask

    task automatic test_stream();
        int stall_cnt = 0;
        int data_cnt  = 0;
        for (int i = 0; i < 1 + 3 * PERIOD; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (i < 1 + PERIOD && obs_stall) stall_cnt++;
            if (bus.o_valid === 1'b1 && bus.o_am_flag === 1'b0) data_cnt++;
            checks++;
            if ({bus.o_valid, bus.o_am_flag, bus.o_period_start, bus.o_data} !== {exp_valid, exp_flag, exp_ps, exp_data}) begin
                failures++;
                $display("FAIL stream_out cyc=%0d got v/am/ps=%b%b%b data=%h exp %b%b%b data=%h", cyc,
                         bus.o_valid, bus.o_am_flag, bus.o_period_start, bus.o_data, exp_valid, exp_flag, exp_ps, exp_data);
            end
            checks++;
            if ({obs_stall, obs_idx} !== {pre_stall, pre_idx}) begin
                failures++;
                $display("FAIL stream_stall cyc=%0d got stall=%b idx=%0d exp stall=%b idx=%0d", cyc, obs_stall, obs_idx, pre_stall, pre_idx);
            end
        end
        checks++;
        if (stall_cnt != 1 + N_LANES) begin
            failures++;
            $display("FAIL stream_stall_count got %0d exp %0d", stall_cnt, 1 + N_LANES);
        end
        checks++;
        if (data_cnt != 3 * N_LANES * (AM_PERIOD - 1)) begin
            failures++;
            $display("FAIL stream_data_count got %0d exp %0d", data_cnt, 3 * N_LANES * (AM_PERIOD - 1));
        end
    endtask

    task automatic test_enable_toggle();
        int guard = 0;
        int am_cnt = 0;
        while (!(m_pos == 0 && !m_init) && guard < 4 * PERIOD) begin
            tick(1'b1, 1'b0, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 4 * PERIOD) begin
            failures++;
            $display("FAIL toggle_sync got no burst start within %0d cycles exp one", guard);
        end
        for (int i = 0; i < 2 * PERIOD; i++) begin
            tick(i % 2 == 0, 1'b0, 1'b0);
            if (i < 2 * N_LANES && bus.o_am_flag === 1'b1) am_cnt++;
            checks++;
            if ({bus.o_valid, bus.o_am_flag, bus.o_period_start, bus.o_data} !== {exp_valid, exp_flag, exp_ps, exp_data}) begin
                failures++;
                $display("FAIL toggle_out cyc=%0d got v/am/ps=%b%b%b data=%h exp %b%b%b data=%h", cyc,
                         bus.o_valid, bus.o_am_flag, bus.o_period_start, bus.o_data, exp_valid, exp_flag, exp_ps, exp_data);
            end
            checks++;
            if ({obs_stall, obs_idx} !== {pre_stall, pre_idx}) begin
                failures++;
                $display("FAIL toggle_stall cyc=%0d got stall=%b idx=%0d exp stall=%b idx=%0d", cyc, obs_stall, obs_idx, pre_stall, pre_idx);
            end
        end
        checks++;
        if (am_cnt != N_LANES) begin
            failures++;
            $display("FAIL toggle_am_count got %0d exp %0d", am_cnt, N_LANES);
        end
    endtask

    task automatic test_force_am();
        int guard = 0;
        int am_cnt = 0;
        while (m_pos != N_LANES + 4 && guard < 4 * PERIOD) begin
            tick(1'b1, 1'b0, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 4 * PERIOD) begin
            failures++;
            $display("FAIL force_sync got no 5th data cycle within %0d cycles exp one", guard);
        end
        for (int i = 0; i < 1 + N_LANES + PERIOD; i++) begin
            tick(1'b1, i == 0, 1'b0);
            if (i >= 1 && i <= N_LANES && bus.o_am_flag === 1'b1) am_cnt++;
            checks++;
            if ({bus.o_valid, bus.o_am_flag, bus.o_period_start, bus.o_data} !== {exp_valid, exp_flag, exp_ps, exp_data}) begin
                failures++;
                $display("FAIL force_out cyc=%0d got v/am/ps=%b%b%b data=%h exp %b%b%b data=%h", cyc,
                         bus.o_valid, bus.o_am_flag, bus.o_period_start, bus.o_data, exp_valid, exp_flag, exp_ps, exp_data);
            end
            checks++;
            if ({obs_stall, obs_idx} !== {pre_stall, pre_idx}) begin
                failures++;
                $display("FAIL force_stall cyc=%0d got stall=%b idx=%0d exp stall=%b idx=%0d", cyc, obs_stall, obs_idx, pre_stall, pre_idx);
            end
        end
        checks++;
        if (am_cnt != N_LANES) begin
            failures++;
            $display("FAIL force_am_count got %0d exp %0d", am_cnt, N_LANES);
        end
    endtask

    task automatic test_force_hold();
        int guard = 0;
        int am_cnt = 0;
        while (!(m_pos == 0 && !m_init) && guard < 4 * PERIOD) begin
            tick(1'b1, 1'b0, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 4 * PERIOD) begin
            failures++;
            $display("FAIL hold_sync got no burst start within %0d cycles exp one", guard);
        end
        for (int i = 0; i < PERIOD; i++) begin
            tick(1'b1, i < N_LANES, 1'b0);
            if (bus.o_am_flag === 1'b1) am_cnt++;
            checks++;
            if ({bus.o_valid, bus.o_am_flag, bus.o_period_start, bus.o_data} !== {exp_valid, exp_flag, exp_ps, exp_data}) begin
                failures++;
                $display("FAIL hold_out cyc=%0d got v/am/ps=%b%b%b data=%h exp %b%b%b data=%h", cyc,
                         bus.o_valid, bus.o_am_flag, bus.o_period_start, bus.o_data, exp_valid, exp_flag, exp_ps, exp_data);
            end
        end
        checks++;
        if (am_cnt != N_LANES) begin
            failures++;
            $display("FAIL hold_am_count got %0d exp %0d", am_cnt, N_LANES);
        end
    endtask

    task automatic test_reset_mid_burst();
        int guard = 0;
        while (!(m_pos == 2 && !m_init) && guard < 4 * PERIOD) begin
            tick(1'b1, 1'b0, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 4 * PERIOD) begin
            failures++;
            $display("FAIL midrst_sync got no lane 2 within %0d cycles exp one", guard);
        end
        tick(1'b1, 1'b0, 1'b1);
        checks++;
        if ({bus.o_valid, bus.o_am_flag, bus.o_period_start, bus.o_data} !== {3'b000, {NB_BLOCK{1'b0}}}) begin
            failures++;
            $display("FAIL midrst_zero cyc=%0d got v/am/ps=%b%b%b data=%h exp all zero",
                     cyc, bus.o_valid, bus.o_am_flag, bus.o_period_start, bus.o_data);
        end
        for (int i = 0; i < 1 + N_LANES + 2; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            checks++;
            if ({bus.o_valid, bus.o_am_flag, bus.o_period_start, bus.o_data} !== {exp_valid, exp_flag, exp_ps, exp_data}) begin
                failures++;
                $display("FAIL midrst_out cyc=%0d got v/am/ps=%b%b%b data=%h exp %b%b%b data=%h", cyc,
                         bus.o_valid, bus.o_am_flag, bus.o_period_start, bus.o_data, exp_valid, exp_flag, exp_ps, exp_data);
            end
            checks++;
            if ({obs_stall, obs_idx} !== {pre_stall, pre_idx}) begin
                failures++;
                $display("FAIL midrst_stall cyc=%0d got stall=%b idx=%0d exp stall=%b idx=%0d", cyc, obs_stall, obs_idx, pre_stall, pre_idx);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            tick($urandom_range(3, 0) != 0, $urandom_range(39, 0) == 0, 1'b0);
            checks++;
            if ({bus.o_valid, bus.o_am_flag, bus.o_period_start, bus.o_data} !== {exp_valid, exp_flag, exp_ps, exp_data}) begin
                failures++;
                $display("FAIL random_out cyc=%0d got v/am/ps=%b%b%b data=%h exp %b%b%b data=%h", cyc,
                         bus.o_valid, bus.o_am_flag, bus.o_period_start, bus.o_data, exp_valid, exp_flag, exp_ps, exp_data);
            end
            checks++;
            if ({obs_stall, obs_idx} !== {pre_stall, pre_idx}) begin
                failures++;
                $display("FAIL random_stall cyc=%0d got stall=%b idx=%0d exp stall=%b idx=%0d", cyc, obs_stall, obs_idx, pre_stall, pre_idx);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N_LANES; i++)
            am_table[i] = {$urandom, $urandom, 2'($urandom)};
        for (int i = 0; i < DEPTH; i++)
            dmem[i] = {$urandom, $urandom, 2'($urandom)};
        bus.i_enable   = 1'b0;
        bus.i_force_am = 1'b0;
        bus.i_data     = '0;
        bus.i_am_block = '0;
        m_init = 1'b1; m_pos = 0; m_rd = 0; up_idx = 0; cyc = 0;
        checks = 0; failures = 0;
        exp_valid = 0; exp_flag = 0; exp_ps = 0; exp_data = '0;

        test_reset();
        test_stream();
        test_enable_toggle();
        test_force_am();
        test_force_hold();
        test_reset_mid_burst();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
